// File: rtl/mem_arb_2to1.sv
// Two-to-one round-robin memory port arbiter. An in-order route FIFO of
// requester IDs steers each memory response back to the port that issued it.
module mem_arb_2to1 #(
  parameter int p_max_outstanding = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,

  input  logic [76:0]                          req0_msg,
  input  logic                                 req0_val,
  output logic                                 req0_rdy,
  output logic [46:0]                          resp0_msg,
  output logic                                 resp0_val,
  input  logic                                 resp0_rdy,

  input  logic [76:0]                          req1_msg,
  input  logic                                 req1_val,
  output logic                                 req1_rdy,
  output logic [46:0]                          resp1_msg,
  output logic                                 resp1_val,
  input  logic                                 resp1_rdy,

  output logic [76:0]                          mem_req_msg,
  output logic                                 mem_req_val,
  input  logic                                 mem_req_rdy,
  input  logic [46:0]                          mem_resp_msg,
  input  logic                                 mem_resp_val,
  output logic                                 mem_resp_rdy,

  output logic [$clog2(p_max_outstanding):0]   outstanding,
  output logic                                 err_spurious
);

  localparam int PTR_W = $clog2(p_max_outstanding);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(p_max_outstanding);

  logic [p_max_outstanding-1:0] route_id;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;
  logic                         last;

  logic full;
  logic empty;
  logic grant_id;
  logic grant_en;
  logic grant0;
  logic grant1;
  logic push;
  logic pop;
  logic head_id;

  // Full/empty come from registered state only, so a same-cycle pop never
  // frees a slot for a push and a same-cycle push never feeds a response.
  always_comb begin
    full     = (count == DEPTH);
    empty    = (count == '0);
    grant_id = (req0_val & req1_val) ? ~last : req1_val;
    grant_en = (req0_val | req1_val) & ~full;
    grant0   = grant_en & ~grant_id;
    grant1   = grant_en & grant_id;
    head_id  = route_id[rd_ptr];
  end

  assign mem_req_val = grant_en;
  assign mem_req_msg = grant1 ? req1_msg : (grant0 ? req0_msg : '0);
  assign req0_rdy    = grant0 & mem_req_rdy;
  assign req1_rdy    = grant1 & mem_req_rdy;
  assign push        = grant_en & mem_req_rdy;

  // With nothing outstanding the memory side is always ready, so a stray
  // response is swallowed and flagged rather than stalling the memory.
  assign resp0_msg    = mem_resp_msg;
  assign resp1_msg    = mem_resp_msg;
  assign resp0_val    = mem_resp_val & ~empty & ~head_id;
  assign resp1_val    = mem_resp_val & ~empty & head_id;
  assign mem_resp_rdy = empty ? 1'b1 : (head_id ? resp1_rdy : resp0_rdy);
  assign pop          = mem_resp_val & mem_resp_rdy & ~empty;

  assign outstanding = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last         <= 1'b1;
      err_spurious <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        last   <= grant_id;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (mem_resp_val && empty) begin
        err_spurious <= 1'b1;
      end
    end
  end

  // Route storage carries no reset; entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      route_id[wr_ptr] <= grant_id;
    end
  end

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Bench for mem_arb_2to1: queue-based routing model, end-to-end response
// scoreboard, a simple one-cycle memory, and directed scenarios.
module tb_mem_arb_2to1;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [76:0] req0_msg, req1_msg, mem_req_msg;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [46:0] resp0_msg, resp1_msg, mem_resp_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic        mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [2:0]  outstanding;
  logic        err_spurious;

  always #5 clk = ~clk;

  mem_arb_2to1 #(.p_max_outstanding(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Request: type[76:74] opaque[73:66] addr[65:34] len[33:32] data[31:0]
  function automatic logic [76:0] mk_req(input bit port, input int seq, input logic [31:0] addr);
    logic [7:0] op;
    op = {port, 7'(seq)};
    return {3'd0, op, addr, 2'd0, ~addr};
  endfunction

  // Memory contents: word at addr reads as addr ^ C0DE0000
  function automatic logic [46:0] resp_of(input logic [76:0] r);
    return {r[76:74], r[73:66], 2'b00, r[33:32], r[65:34] ^ 32'hC0DE_0000};
  endfunction

  // Stimulus buffers: main writes, driver consumes
  logic [76:0] src0_buf [0:63];
  logic [76:0] src1_buf [0:63];
  int src0_wr = 0, src1_wr = 0, src0_rd = 0, src1_rd = 0;
  logic mem_en, spur_req;

  // Model and scoreboard state (owned by the driver/checker process)
  bit          rq[$];
  bit          last_m, err_m;
  logic [46:0] exp0[$], exp1[$];
  logic [76:0] mq[$];
  int          acc = 0, r0_cnt = 0;
  logic [31:0] r0_last_data;
  int          glog[$];
  bit          f_req0, f_req1, f_mreq, f_mresp, spur_driven;
  logic [76:0] f_mreq_msg;

  initial begin : drive_and_check
    bit full, empty, gid, any, head, e_mrr;
    logic [76:0] e_msg;
    req0_val = 0; req0_msg = '0; req1_val = 0; req1_msg = '0;
    mem_resp_val = 0; mem_resp_msg = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        src0_rd = src0_wr; src1_rd = src1_wr; mq.delete();
      end else begin
        if (f_req0) src0_rd++;
        if (f_req1) src1_rd++;
        if (f_mresp && !spur_driven) void'(mq.pop_front());
        if (f_mreq) mq.push_back(f_mreq_msg);
      end
      #1;
      req0_val = (src0_rd != src0_wr);
      req0_msg = req0_val ? src0_buf[src0_rd] : '0;
      req1_val = (src1_rd != src1_wr);
      req1_msg = req1_val ? src1_buf[src1_rd] : '0;
      spur_driven = spur_req;
      if (spur_req) begin
        mem_resp_val = 1; mem_resp_msg = 47'h0000_1234_5678;
      end else if (mem_en && mq.size() > 0) begin
        mem_resp_val = 1; mem_resp_msg = resp_of(mq[0]);
      end else begin
        mem_resp_val = 0; mem_resp_msg = '0;
      end

      @(negedge clk);
      if (!rst_n) begin
        rq.delete(); last_m = 1; err_m = 0; exp0.delete(); exp1.delete();
        f_req0 = 0; f_req1 = 0; f_mreq = 0; f_mresp = 0;
        check("rst_outstanding", outstanding, 0);
        check("rst_resp0_val", resp0_val, 0);
        check("rst_resp1_val", resp1_val, 0);
        check("rst_mem_resp_rdy", mem_resp_rdy, 1);
        check("rst_err_spurious", err_spurious, 0);
        check("rst_mem_req_val", mem_req_val, req0_val | req1_val);
      end else begin
        full  = (rq.size() == P);
        empty = (rq.size() == 0);
        gid   = (req0_val && req1_val) ? !last_m : req1_val;
        any   = (req0_val || req1_val) && !full;
        e_msg = !any ? '0 : (gid ? req1_msg : req0_msg);
        check("mem_req_val", mem_req_val, any);
        check("mem_req_msg", mem_req_msg, e_msg);
        check("req0_rdy", req0_rdy, any && !gid && mem_req_rdy);
        check("req1_rdy", req1_rdy, any && gid && mem_req_rdy);
        head  = empty ? 1'b0 : rq[0];
        e_mrr = empty ? 1'b1 : (head ? resp1_rdy : resp0_rdy);
        check("resp0_val", resp0_val, !empty && !head && mem_resp_val);
        check("resp1_val", resp1_val, !empty && head && mem_resp_val);
        check("mem_resp_rdy", mem_resp_rdy, e_mrr);
        if (!empty) begin
          check("resp0_msg", resp0_msg, mem_resp_msg);
          check("resp1_msg", resp1_msg, mem_resp_msg);
        end
        check("outstanding", outstanding, rq.size());
        check("err_spurious", err_spurious, err_m);

        f_req0 = req0_val && req0_rdy;
        f_req1 = req1_val && req1_rdy;
        if (f_req0) begin exp0.push_back(resp_of(req0_msg)); acc++; glog.push_back(0); end
        if (f_req1) begin exp1.push_back(resp_of(req1_msg)); acc++; glog.push_back(1); end
        if (resp0_val && resp0_rdy) begin
          check("resp0_pending", exp0.size() != 0, 1);
          if (exp0.size() != 0) check("resp0_data", resp0_msg, exp0.pop_front());
          r0_cnt++; r0_last_data = resp0_msg[31:0];
        end
        if (resp1_val && resp1_rdy) begin
          check("resp1_pending", exp1.size() != 0, 1);
          if (exp1.size() != 0) check("resp1_data", resp1_msg, exp1.pop_front());
        end
        f_mreq = mem_req_val && mem_req_rdy;
        f_mreq_msg = mem_req_msg;
        f_mresp = mem_resp_val && mem_resp_rdy;

        if (!empty && mem_resp_val && e_mrr) void'(rq.pop_front());
        if (empty && mem_resp_val) err_m = 1;
        if (any && mem_req_rdy) begin rq.push_back(gid); last_m = gid; end
      end
    end
  end

  function automatic bit is_idle();
    return src0_rd == src0_wr && src1_rd == src1_wr && mq.size() == 0 &&
           outstanding == 0 && exp0.size() == 0 && exp1.size() == 0;
  endfunction

  task automatic wait_out(input int n);
    int k = 0;
    while (outstanding != n && k < 50) begin @(posedge clk); #2; k++; end
    check("wait_outstanding", outstanding, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!is_idle() && k < 100) begin @(posedge clk); #2; k++; end
    check("wait_idle", is_idle(), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic push0(input int seq, input logic [31:0] addr);
    src0_buf[src0_wr] = mk_req(1'b0, seq, addr); src0_wr++;
  endtask

  task automatic push1(input int seq, input logic [31:0] addr);
    src1_buf[src1_wr] = mk_req(1'b1, seq, addr); src1_wr++;
  endtask

  initial begin : main
    int base, peak, seen1, g0, a0;
    int exp_g[6];
    exp_g = '{0, 1, 0, 1, 0, 1};
    rst_n = 0; mem_en = 0; spur_req = 0;
    mem_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Single requester: eight reads on port 0
    mem_en = 1; base = r0_cnt; peak = 0; seen1 = 0;
    for (int i = 0; i < 8; i++) push0(i, 32'(i * 4));
    for (int k = 0; k < 60 && (r0_cnt - base) != 8; k++) begin
      @(posedge clk); #2;
      if (outstanding > peak) peak = outstanding;
      if (resp1_val) seen1++;
    end
    check("single_resp_count", r0_cnt - base, 8);
    check("single_last_data", r0_last_data, 32'hC0DE_001C);
    check("single_peak", peak, 1);
    check("single_no_resp1", seen1, 0);
    wait_idle();

    // Contention right after reset: grants alternate starting with port 0
    do_reset();
    g0 = glog.size();
    for (int i = 0; i < 3; i++) begin push0(16 + i, 32'h100 + 32'(i * 4)); push1(16 + i, 32'h200 + 32'(i * 4)); end
    wait_idle();
    check("cont_grant_count", glog.size() - g0, 6);
    for (int i = 0; i < 6; i++) if (g0 + i < glog.size()) check("cont_grant_order", glog[g0 + i], exp_g[i]);

    // Full FIFO: memory silent, both ports streaming
    mem_en = 0; a0 = acc;
    for (int i = 0; i < 6; i++) begin push0(32 + i, 32'h300 + 32'(i * 4)); push1(32 + i, 32'h400 + 32'(i * 4)); end
    wait_out(4);
    repeat (2) begin @(posedge clk); #2; end
    check("full_accepts", acc - a0, 4);
    check("full_outstanding", outstanding, 4);
    check("full_req0_rdy", req0_rdy, 0);
    check("full_req1_rdy", req1_rdy, 0);
    check("full_mem_req_val", mem_req_val, 0);
    mem_en = 1;
    @(posedge clk); #2;
    check("full_resp_cycle_val", mem_resp_val, 1);
    check("full_resp_cycle_rdy", req0_rdy | req1_rdy, 0);
    @(posedge clk); #2;
    check("full_after_pop_accepts", acc - a0, 4);
    check("full_after_pop_rdy", req0_rdy | req1_rdy, 1);
    @(posedge clk); #2;
    check("full_one_new_accept", acc - a0, 5);
    wait_idle();

    // Response backpressure: head belongs to port 1, which stalls
    mem_en = 0;
    push1(48, 32'h500); wait_out(1);
    push0(48, 32'h600); wait_out(2);
    base = r0_cnt;
    resp1_rdy = 0; mem_en = 1;
    repeat (3) begin
      @(posedge clk); #2;
      check("bp_mem_resp_rdy", mem_resp_rdy, 0);
      check("bp_resp1_val", resp1_val, 1);
      check("bp_outstanding", outstanding, 2);
    end
    check("bp_no_resp0_yet", r0_cnt - base, 0);
    resp1_rdy = 1;
    wait_idle();
    check("bp_resp0_after", r0_cnt - base, 1);

    // Spurious response with nothing outstanding
    do_reset();
    spur_req = 1;
    @(posedge clk); #2 spur_req = 0;
    check("sp_mem_resp_val", mem_resp_val, 1);
    check("sp_mem_resp_rdy", mem_resp_rdy, 1);
    check("sp_resp0_val", resp0_val, 0);
    check("sp_resp1_val", resp1_val, 0);
    check("sp_err_before_edge", err_spurious, 0);
    @(posedge clk); #2;
    check("sp_err_set", err_spurious, 1);
    repeat (3) @(posedge clk);
    #2 check("sp_err_sticky", err_spurious, 1);

    // Asynchronous reset with three entries in flight
    mem_en = 0;
    for (int i = 0; i < 3; i++) push0(64 + i, 32'h700 + 32'(i * 4));
    wait_out(3);
    rst_n = 0;
    #1;
    check("rm_outstanding", outstanding, 0);
    check("rm_resp0_val", resp0_val, 0);
    check("rm_resp1_val", resp1_val, 0);
    check("rm_mem_resp_rdy", mem_resp_rdy, 1);
    check("rm_err_cleared", err_spurious, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1; mem_en = 1;
    g0 = glog.size();
    push0(80, 32'h800); push1(80, 32'h900);
    wait_idle();
    check("rm_tie_count", glog.size() - g0, 2);
    if (glog.size() - g0 >= 2) begin
      check("rm_first_grant", glog[g0], 0);
      check("rm_second_grant", glog[g0 + 1], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb_2to1.md
# mem_arb_2to1

Two-to-one memory port arbiter that lets the processor's instruction and data memory streams share a single `ram_wrap` instance. It accepts `mem_req_4B_t` requests on two val/rdy ports and forwards them unchanged to one memory request port using round-robin arbitration. It records which requester was granted in an in-order route FIFO, and uses that FIFO to steer each `mem_resp_4B_t` response back to the requester that issued it. It sits between `lab2_proc_ProcAltVRTL` (imem port = requester 0, dmem port = requester 1) and a shared memory.

## Interface
- `p_max_outstanding`, 4: route FIFO depth, i.e. the maximum number of granted-but-unanswered requests; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_msg`  in  mem_req_4B_t (77)  requester 0 (imem) request.
- `req0_val` in 1 / `req0_rdy` out 1  requester 0 request handshake.
- `resp0_msg`  out  mem_resp_4B_t (47)  response to requester 0.
- `resp0_val` out 1 / `resp0_rdy` in 1  requester 0 response handshake.
- `req1_msg`, `req1_val`, `req1_rdy`, `resp1_msg`, `resp1_val`, `resp1_rdy`: same as port 0, for requester 1 (dmem).
- `mem_req_msg` out 77 / `mem_req_val` out 1 / `mem_req_rdy` in 1  shared memory request.
- `mem_resp_msg` in 47 / `mem_resp_val` in 1 / `mem_resp_rdy` out 1  shared memory response.
- `outstanding`  out  $clog2(p_max_outstanding)+1  current number of route FIFO entries.
- `err_spurious`  out  1  sticky flag: a memory response arrived while no request was outstanding.

## Operation
- **State**
  - Route FIFO of 1-bit requester IDs (depth `p_max_outstanding`), built from a read pointer, a write pointer and a count.
  - Round-robin pointer `last` (1 bit): the ID of the last granted requester.
  - `err_spurious` register.
- **Arbitration** (combinational)
  - If exactly one `reqN_val` is high, that requester is granted.
  - If both are high, the requester ≠ `last` is granted.
  - No grant is made while the FIFO is full.
- **Request path**
  - `mem_req_val` = (granted requester's val) & !full.
  - `mem_req_msg` = granted requester's msg; zero when there is no grant.
  - `reqN_rdy` = grantN & !full & `mem_req_rdy`.
  - The message passes through bit-exact; the opaque field is not modified.
- **Request fire** (`mem_req_val & mem_req_rdy`)
  - Push the granted ID into the FIFO.
  - Set `last` ← granted ID.
  - `last` changes only on a fire.
- **Response path**, FIFO non-empty, head ID = h:
  - `resp{h}_val` = `mem_resp_val`; the other port's val = 0.
  - Both `respN_msg` = `mem_resp_msg`.
  - `mem_resp_rdy` = `resp{h}_rdy`.
  - Pop the FIFO on `mem_resp_val & mem_resp_rdy`.
- **Response path**, FIFO empty:
  - Both `respN_val` = 0 and `mem_resp_rdy` = 1.
  - A `mem_resp_val` in this state is discarded and sets `err_spurious`. It stays set until reset.
- **Ordering**
  - The memory returns responses in request order. This block never reorders.
  - Head-of-line blocking is intended: a stalled requester stalls responses to the other.
- **Simultaneous push and pop**
  - Allowed when the FIFO is neither full nor empty; count is unchanged and both pointers advance.
  - When full, a pop in the same cycle does not enable a push. Full is evaluated from registered state; there is no bypass.
  - When empty, a push in the same cycle does not enable a response. There is no bypass.
- Pointers wrap modulo `p_max_outstanding`.

## Timing
- **Reset** (async assert, sync-safe deassert):
  - FIFO empty, `outstanding`=0, `last`=1 (requester 0 wins the first tie), `err_spurious`=0.
  - Hence `mem_req_val`=0 unless a request is valid, `resp0_val`=`resp1_val`=0, and `mem_resp_rdy`=1.
- **Latency**: zero cycles in both directions. The request reaches the memory in the same cycle it is valid; the response reaches the requester in the same cycle it is valid.
- **Combinational paths**:
  - reqN_val → mem_req_val
  - mem_req_rdy → reqN_rdy
  - mem_resp_val → respN_val
  - respN_rdy → mem_resp_rdy
  - No path from any rdy to any val in the same direction.
- Throughput: one request and one response per cycle.
- Requesters must hold `reqN_msg` stable while `reqN_val` is high and not accepted.
- **Reset mid-operation**: all in-flight route entries are lost. The surrounding memory is reset by the same reset.

## Test plan
- **Single requester**: 8 reads on port 0 only (addr 0x0,0x4,…,0x1C), memory returns one cycle later → 8 responses on `resp0` in order with data from those addresses; `resp1_val` is never high; `outstanding` peaks at 1.
- **Contention**: both ports hold val high for 6 cycles with `mem_req_rdy`=1 → grants alternate 0,1,0,1,0,1 (port 0 first after reset); responses are routed to matching ports.
- **Full FIFO**: `mem_req_rdy`=1, `mem_resp_val` held 0, both requesters streaming → exactly 4 accepts; `outstanding`=4; both `reqN_rdy`=0 until the first response fires; after it, exactly one new accept in the following cycle.
- **Response backpressure**: head ID=1 with `resp1_rdy`=0 for 3 cycles and `resp0_rdy`=1 → `mem_resp_rdy`=0 for those 3 cycles; no pop; the next entry for port 0 is delivered only after port 1 accepts.
- **Spurious response**: after reset, `mem_resp_val`=1 with FIFO empty → `mem_resp_rdy`=1; `err_spurious`=1 next cycle and stays 1; no `respN_val`.
- **Reset mid-stream**: assert `rst_n`=0 asynchronously with `outstanding`=3 → `outstanding`=0, `respN_val`=0, `last`=1 immediately, without waiting for a clock edge.
